// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared state and mode encodings for the channel scanner
package mux_pkg;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        MANUAL   = 2'd1,
        ESCANEO  = 2'd2
    } estado_t;

    localparam logic MODO_MANUAL  = 1'b0;
    localparam logic MODO_ESCANEO = 1'b1;

endpackage

// File: rtl/mux_escaner_if.sv
// rtl/mux_escaner_if.sv - data, control and strobe bundle of the channel scanner
interface mux_escaner_if #(
    parameter int N_CANALES = 4,
    parameter int ANCHO     = 4,
    parameter int CNT_W     = 16,
    parameter int SEL_W     = $clog2(N_CANALES)
);
    logic [N_CANALES*ANCHO-1:0] i_Datos;
    logic [SEL_W-1:0]           i_Sel;
    logic                       i_Modo;
    logic                       i_Habilita;
    logic [CNT_W-1:0]           i_Periodo;
    logic [ANCHO-1:0]           o_Salida;
    logic [SEL_W-1:0]           o_Canal;
    logic                       o_Valido;
    logic                       o_Fin_Barrido;

    modport slave (
        input  i_Datos, i_Sel, i_Modo, i_Habilita, i_Periodo,
        output o_Salida, o_Canal, o_Valido, o_Fin_Barrido
    );

    modport master (
        output i_Datos, i_Sel, i_Modo, i_Habilita, i_Periodo,
        input  o_Salida, o_Canal, o_Valido, o_Fin_Barrido
    );
endinterface

// File: rtl/mux_escaner_contador_permanencia.sv
// rtl/mux_escaner_contador_permanencia.sv - dwell counter with clear, enable and expiry tick
// A period of 0 behaves as 1; ">=" lets a live period cut force an immediate expiry.
module contador_permanencia #(
    parameter int CNT_W = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] periodo,
    output logic             tick
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] limite;

    assign limite = (periodo == '0) ? CNT_W'(1) : periodo;
    assign tick   = en && !clr && (cnt_q >= (limite - CNT_W'(1)));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/mux_escaner.sv
// rtl/mux_escaner.sv - registered N-channel mux with manual select and timed auto-scan
// Mode entry always yields exactly one valid strobe and suppresses any concurrent advance.
module mux_escaner
    import mux_pkg::*;
#(
    parameter int N_CANALES = 4,
    parameter int ANCHO     = 4,
    parameter int CNT_W     = 16
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    mux_escaner_if.slave  bus
);
    localparam int SEL_W = $clog2(N_CANALES);
    localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(N_CANALES - 1);

    estado_t          state_q, state_d, modo_d;
    logic [SEL_W-1:0] canal_q, canal_d, sel_c;
    logic [ANCHO-1:0] salida_q, salida_d;
    logic             valido_q, valido_d;
    logic             fin_q, fin_d;
    logic             cnt_en, cnt_clr, tick;

    // Out-of-range selects (non power-of-two channel counts) pin to the last channel
    assign sel_c = ({1'b0, bus.i_Sel} >= (SEL_W+1)'(N_CANALES)) ? ULTIMO : bus.i_Sel;

    assign cnt_en  = bus.i_Habilita && (state_q == ESCANEO) && (bus.i_Modo == MODO_ESCANEO);
    assign cnt_clr = bus.i_Habilita && !cnt_en;

    contador_permanencia #(.CNT_W(CNT_W)) u_contador (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .en      (cnt_en),
        .clr     (cnt_clr),
        .periodo (bus.i_Periodo),
        .tick    (tick)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= INACTIVO;
            canal_q  <= '0;
            salida_q <= '0;
            valido_q <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            canal_q  <= canal_d;
            salida_q <= salida_d;
            valido_q <= valido_d;
            fin_q    <= fin_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        canal_d  = canal_q;
        salida_d = salida_q;
        valido_d = 1'b0;
        fin_d    = 1'b0;
        modo_d   = (bus.i_Modo == MODO_ESCANEO) ? ESCANEO : MANUAL;
        if (bus.i_Habilita) begin
            if (state_q != modo_d) begin
                state_d  = modo_d;
                valido_d = 1'b1;
                if (modo_d == MANUAL) begin
                    canal_d = sel_c;
                end
            end else if (state_q == MANUAL) begin
                canal_d  = sel_c;
                valido_d = (sel_c != canal_q);
            end else if (tick) begin
                canal_d  = (canal_q == ULTIMO) ? '0 : canal_q + SEL_W'(1);
                valido_d = 1'b1;
                fin_d    = (canal_q == ULTIMO);
            end
            salida_d = bus.i_Datos[int'(canal_d) * ANCHO +: ANCHO];
        end
    end

    assign bus.o_Salida      = salida_q;
    assign bus.o_Canal       = canal_q;
    assign bus.o_Valido      = valido_q;
    assign bus.o_Fin_Barrido = fin_q;
endmodule

// File: tb/tb_mux_escaner.sv
// tb/tb_mux_escaner.sv - directed vector bench for the channel scanner
module tb_mux_escaner;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_escaner_if #(.N_CANALES(4), .ANCHO(4)) bus4 ();
    mux_escaner_if #(.N_CANALES(3), .ANCHO(8)) bus3 ();

    mux_escaner #(.N_CANALES(4), .ANCHO(4)) dut4 (.i_Clk(clk), .i_Rst(rst), .bus(bus4));
    mux_escaner #(.N_CANALES(3), .ANCHO(8)) dut3 (.i_Clk(clk), .i_Rst(rst), .bus(bus3));

    typedef struct {
        logic [15:0] datos;
        logic [1:0]  sel;
        logic        modo;
        logic        hab;
        logic [15:0] per;
        logic [3:0]  salida;
        logic [1:0]  canal;
        logic        valido;
        logic        fin;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(logic [15:0] d, logic [1:0] s, logic m, logic h, logic [15:0] p,
                              logic [3:0] so, logic [1:0] c, logic va, logic f);
        vec_t x;
        x.datos = d; x.sel = s; x.modo = m; x.hab = h; x.per = p;
        x.salida = so; x.canal = c; x.valido = va; x.fin = f;
        vecs.push_back(x);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk4(string tag, logic [3:0] so, logic [1:0] c, logic va, logic f);
        chk({tag, "_salida"}, 32'(bus4.o_Salida), 32'(so));
        chk({tag, "_canal"},  32'(bus4.o_Canal),  32'(c));
        chk({tag, "_valido"}, 32'(bus4.o_Valido), 32'(va));
        chk({tag, "_fin"},    32'(bus4.o_Fin_Barrido), 32'(f));
    endtask

    task automatic chk3(string tag, logic [7:0] so, logic [1:0] c, logic va, logic f);
        chk({tag, "_salida"}, 32'(bus3.o_Salida), 32'(so));
        chk({tag, "_canal"},  32'(bus3.o_Canal),  32'(c));
        chk({tag, "_valido"}, 32'(bus3.o_Valido), 32'(va));
        chk({tag, "_fin"},    32'(bus3.o_Fin_Barrido), 32'(f));
    endtask

    localparam logic [15:0] DAT = 16'hDCBA;

    initial begin
        logic [1:0] c;
        logic [7:0] esperado;

        bus4.i_Datos = DAT; bus4.i_Sel = 2'd0; bus4.i_Modo = 1'b0;
        bus4.i_Habilita = 1'b0; bus4.i_Periodo = 16'd3;
        bus3.i_Datos = 24'h332211; bus3.i_Sel = 2'd0; bus3.i_Modo = 1'b0;
        bus3.i_Habilita = 1'b0; bus3.i_Periodo = 16'd0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1 chk4("reset", 4'h0, 2'd0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // manual stepping, held select, frozen enable
        v(DAT, 0, 0, 1, 3, 4'hA, 0, 1, 0);
        v(DAT, 0, 0, 1, 3, 4'hA, 0, 0, 0);
        v(DAT, 1, 0, 1, 3, 4'hB, 1, 1, 0);
        v(DAT, 1, 0, 1, 3, 4'hB, 1, 0, 0);
        v(DAT, 2, 0, 1, 3, 4'hC, 2, 1, 0);
        v(DAT, 3, 0, 1, 3, 4'hD, 3, 1, 0);
        v(DAT, 3, 0, 1, 3, 4'hD, 3, 0, 0);
        v(DAT, 0, 0, 0, 3, 4'hD, 3, 0, 0);
        v(DAT, 0, 0, 1, 3, 4'hA, 0, 1, 0);
        // auto-scan, period 3, full sweep
        v(DAT, 0, 1, 1, 3, 4'hA, 0, 1, 0);
        v(DAT, 0, 1, 1, 3, 4'hA, 0, 0, 0);
        v(DAT, 0, 1, 1, 3, 4'hA, 0, 0, 0);
        v(DAT, 0, 1, 1, 3, 4'hB, 1, 1, 0);
        v(DAT, 0, 1, 1, 3, 4'hB, 1, 0, 0);
        v(DAT, 0, 1, 1, 3, 4'hB, 1, 0, 0);
        v(DAT, 0, 1, 1, 3, 4'hC, 2, 1, 0);
        v(DAT, 0, 1, 1, 3, 4'hC, 2, 0, 0);
        v(DAT, 0, 1, 1, 3, 4'hC, 2, 0, 0);
        v(DAT, 0, 1, 1, 3, 4'hD, 3, 1, 0);
        v(DAT, 0, 1, 1, 3, 4'hD, 3, 0, 0);
        v(DAT, 0, 1, 1, 3, 4'hD, 3, 0, 0);
        v(DAT, 0, 1, 1, 3, 4'hA, 0, 1, 1);
        v(DAT, 0, 1, 1, 3, 4'hA, 0, 0, 0);
        // freeze at count 1 of 3 with data churning underneath
        for (int k = 0; k < 5; k++) v(16'h1111, 0, 1, 0, 3, 4'hA, 0, 0, 0);
        v(DAT, 0, 1, 1, 3, 4'hA, 0, 0, 0);
        v(DAT, 0, 1, 1, 3, 4'hB, 1, 1, 0);
        v(DAT, 0, 1, 1, 3, 4'hB, 1, 0, 0);
        v(DAT, 0, 1, 1, 3, 4'hB, 1, 0, 0);
        // mode change on the expiry cycle
        v(DAT, 2, 0, 1, 3, 4'hC, 2, 1, 0);
        v(DAT, 2, 0, 1, 3, 4'hC, 2, 0, 0);
        v(16'hD5BA, 2, 0, 1, 3, 4'h5, 2, 0, 0);
        // scan from current channel, then a live period cut
        v(16'hD5BA, 2, 1, 1, 5, 4'h5, 2, 1, 0);
        v(16'hD5BA, 2, 1, 1, 5, 4'h5, 2, 0, 0);
        v(16'hD5BA, 2, 1, 1, 5, 4'h5, 2, 0, 0);
        v(16'hD5BA, 2, 1, 1, 1, 4'hD, 3, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus4.i_Datos    = vecs[i].datos;
            bus4.i_Sel      = vecs[i].sel;
            bus4.i_Modo     = vecs[i].modo;
            bus4.i_Habilita = vecs[i].hab;
            bus4.i_Periodo  = vecs[i].per;
            @(posedge clk); #1;
            chk4($sformatf("v%0d", i), vecs[i].salida, vecs[i].canal, vecs[i].valido, vecs[i].fin);
        end

        // asynchronous reset mid-scan, no clock edge in between
        rst = 1'b1;
        #1 chk4("rst_async", 4'h0, 2'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        bus4.i_Datos = 16'hD5B3; bus4.i_Sel = 2'd0; bus4.i_Modo = 1'b0;
        bus4.i_Habilita = 1'b1;
        @(posedge clk); #1;
        chk4("rst_resume", 4'h3, 2'd0, 1'b1, 1'b0);

        // three-channel, 8-bit instance: select clamp then period-0 scan
        bus3.i_Habilita = 1'b1; bus3.i_Sel = 2'd3;
        @(posedge clk); #1;
        chk3("n3_clamp", 8'h33, 2'd2, 1'b1, 1'b0);
        bus3.i_Sel = 2'd2;
        @(posedge clk); #1;
        chk3("n3_same", 8'h33, 2'd2, 1'b0, 1'b0);
        bus3.i_Modo = 1'b1;
        @(posedge clk); #1;
        chk3("n3_entry", 8'h33, 2'd2, 1'b1, 1'b0);
        c = 2'd2;
        for (int k = 0; k < 6; k++) begin
            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
            esperado = (c == 2'd0) ? 8'h11 : (c == 2'd1) ? 8'h22 : 8'h33;
            @(posedge clk); #1;
            chk3($sformatf("n3_scan%0d", k), esperado, c, 1'b1, c == 2'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
